// File: rtl/pipeline_ctrl.sv
// Stall/flush controller: RAW hazards, EX branches, MEM handshake with watchdog; FORWARDING_EN narrows hazards to load-use.
// Freeze/flush outputs are combinational (same-cycle); mem_err, stall_cnt and the FSM are registered.
module pipeline_ctrl #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       id_src1,
    input  logic             id_src1_valid,
    input  logic [3:0]       id_src2,
    input  logic             id_two_src,
    input  logic [3:0]       exe_dest,
    input  logic [3:0]       mem_dest,
    input  logic             exe_wb_en,
    input  logic             mem_wb_en,
    input  logic             exe_mem_r_en,
    input  logic             exe_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             stat_clr,
    output logic             freeze_pc,
    output logic             freeze_if_id,
    output logic             freeze_id_ex,
    output logic             freeze_ex_mem,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             hazard_stall,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WC_W = $clog2(MAX_WAIT + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_TIMEOUT = 2'd2;

    logic [1:0]       r_state;
    logic [WC_W-1:0]  r_wait_cnt;
    logic             r_mem_err;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_m1;
    logic w_m2;
    logic w_hz;
    logic w_mem_stall;

    function automatic logic match(input logic [3:0] s, input logic [3:0] d, input logic en);
        return en && (s == d);
    endfunction

`ifdef FORWARDING_EN
    assign w_m1 = exe_mem_r_en & match(id_src1, exe_dest, exe_wb_en);
    assign w_m2 = exe_mem_r_en & match(id_src2, exe_dest, exe_wb_en);
`else
    assign w_m1 = match(id_src1, exe_dest, exe_wb_en) | match(id_src1, mem_dest, mem_wb_en);
    assign w_m2 = match(id_src2, exe_dest, exe_wb_en) | match(id_src2, mem_dest, mem_wb_en);
`endif

    assign w_hz        = (id_src1_valid & w_m1) | (id_two_src & w_m2);
    assign w_mem_stall = mem_req & ~mem_ready & (r_state != S_TIMEOUT);

    // Gated by rst so freezes drop the moment reset hits, even mid-access.
    always_comb begin
        freeze_pc     = 1'b0;
        freeze_if_id  = 1'b0;
        freeze_id_ex  = 1'b0;
        freeze_ex_mem = 1'b0;
        flush_if_id   = 1'b0;
        flush_id_ex   = 1'b0;
        hazard_stall  = 1'b0;
        if (!rst) begin
            if (w_mem_stall) begin
                freeze_pc     = 1'b1;
                freeze_if_id  = 1'b1;
                freeze_id_ex  = 1'b1;
                freeze_ex_mem = 1'b1;
            end else if (exe_branch_taken) begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (w_hz) begin
                freeze_pc    = 1'b1;
                freeze_if_id = 1'b1;
                flush_id_ex  = 1'b1;
                hazard_stall = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mem_req && !mem_ready) begin
                        r_state    <= S_WAIT;
                        r_wait_cnt <= WC_W'(1);
                    end
                end
                S_WAIT: begin
                    if (!mem_req || mem_ready) begin
                        r_state    <= S_IDLE;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == WC_W'(MAX_WAIT - 1)) begin
                        r_state   <= S_TIMEOUT;
                        r_mem_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WC_W'(1);
                    end
                end
                S_TIMEOUT: begin
                    r_state    <= S_IDLE;
                    r_wait_cnt <= '0;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (stat_clr) begin
            r_stall_cnt <= '0;
        end else if (freeze_pc && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign mem_err   = r_mem_err;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: vector table, hand-written multi-cycle sequences, and random traffic vs a reference model.
module tb_pipeline_ctrl;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 2;
    localparam int CMAX     = (1 << CNT_W) - 1;

    localparam logic [6:0] O_0  = 7'b0000000;
    localparam logic [6:0] O_MS = 7'b1111000;
    localparam logic [6:0] O_BR = 7'b0000110;
    localparam logic [6:0] O_HZ = 7'b1100011;
`ifdef FORWARDING_EN
    localparam logic [6:0] O_NF = O_0;
`else
    localparam logic [6:0] O_NF = O_HZ;
`endif

    typedef struct packed {
        logic [3:0] s1;
        logic       s1v;
        logic [3:0] s2;
        logic       two;
        logic [3:0] ed;
        logic [3:0] md;
        logic       ewb;
        logic       mwb;
        logic       eld;
        logic       br;
        logic       mreq;
        logic       mrdy;
        logic       clr;
    } in_t;

    typedef struct {
        in_t        i;
        logic [6:0] e;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] id_src1 = '0, id_src2 = '0, exe_dest = '0, mem_dest = '0;
    logic id_src1_valid = 0, id_two_src = 0, exe_wb_en = 0, mem_wb_en = 0;
    logic exe_mem_r_en = 0, exe_branch_taken = 0, mem_req = 0, mem_ready = 0, stat_clr = 0;
    logic freeze_pc, freeze_if_id, freeze_id_ex, freeze_ex_mem;
    logic flush_if_id, flush_id_ex, hazard_stall, mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [6:0] w_o;

    int checks = 0;
    int errors = 0;

    // Reference model: length of the current stall run, timeout cycle flag, sticky error, counter.
    int m_k   = 0;
    bit m_to  = 0;
    bit m_err = 0;
    int m_cnt = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src1_valid(id_src1_valid),
        .id_src2(id_src2), .id_two_src(id_two_src),
        .exe_dest(exe_dest), .mem_dest(mem_dest),
        .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en),
        .exe_mem_r_en(exe_mem_r_en), .exe_branch_taken(exe_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .stat_clr(stat_clr),
        .freeze_pc(freeze_pc), .freeze_if_id(freeze_if_id),
        .freeze_id_ex(freeze_id_ex), .freeze_ex_mem(freeze_ex_mem),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .hazard_stall(hazard_stall), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    assign w_o = {freeze_pc, freeze_if_id, freeze_id_ex, freeze_ex_mem,
                  flush_if_id, flush_id_ex, hazard_stall};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic in_t vin(input int s1, input bit s1v, input int s2, input bit two,
                                input int ed, input bit ewb, input bit eld,
                                input int md, input bit mwb, input bit br,
                                input bit mreq = 0, input bit mrdy = 0, input bit clr = 0);
        in_t v;
        v.s1 = 4'(s1); v.s1v = s1v; v.s2 = 4'(s2); v.two = two;
        v.ed = 4'(ed); v.ewb = ewb; v.eld = eld; v.md = 4'(md); v.mwb = mwb;
        v.br = br; v.mreq = mreq; v.mrdy = mrdy; v.clr = clr;
        return v;
    endfunction

    function automatic bit hz_of(input in_t v);
        bit m1, m2;
`ifdef FORWARDING_EN
        m1 = v.eld && v.ewb && (v.s1 == v.ed);
        m2 = v.eld && v.ewb && (v.s2 == v.ed);
`else
        m1 = (v.ewb && (v.s1 == v.ed)) || (v.mwb && (v.s1 == v.md));
        m2 = (v.ewb && (v.s2 == v.ed)) || (v.mwb && (v.s2 == v.md));
`endif
        return (v.s1v && m1) || (v.two && m2);
    endfunction

    function automatic logic [6:0] model_out(input in_t v);
        if (v.mreq && !v.mrdy && !m_to) return O_MS;
        if (v.br) return O_BR;
        if (hz_of(v)) return O_HZ;
        return O_0;
    endfunction

    task automatic model_step(input in_t v, input logic [6:0] o);
        bit stall;
        stall = v.mreq && !v.mrdy && !m_to;
        if (v.clr) m_cnt = 0;
        else if (o[6] && m_cnt < CMAX) m_cnt++;
        if (m_to) begin
            m_to = 0;
            m_k  = 0;
        end else if (stall) begin
            m_k++;
            if (m_k == MAX_WAIT) begin
                m_to  = 1;
                m_err = 1;
                m_k   = 0;
            end
        end else begin
            m_k = 0;
        end
    endtask

    task automatic drive(input in_t v);
        id_src1 = v.s1; id_src1_valid = v.s1v; id_src2 = v.s2; id_two_src = v.two;
        exe_dest = v.ed; mem_dest = v.md; exe_wb_en = v.ewb; mem_wb_en = v.mwb;
        exe_mem_r_en = v.eld; exe_branch_taken = v.br;
        mem_req = v.mreq; mem_ready = v.mrdy; stat_clr = v.clr;
    endtask

    // Entered at posedge+1; checks mid-cycle, then advances to the next posedge+1.
    task automatic cycle(input in_t v, input string nm, input bit use_t = 0,
                         input logic [6:0] texp = '0);
        logic [6:0] e;
        drive(v);
        #4;
        e = model_out(v);
        chk({nm, " outs"}, 32'(w_o), 32'(e));
        chk({nm, " mem_err"}, 32'(mem_err), 32'(m_err));
        chk({nm, " stall_cnt"}, 32'(stall_cnt), 32'(m_cnt));
        if (use_t) chk({nm, " expected"}, 32'(w_o), 32'(texp));
        model_step(v, e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t tbl[10];
        in_t  z, lu, m, mr, mb, mrb, r;

        z   = vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        lu  = vin(3, 1, 0, 0, 3, 1, 1, 0, 0, 0);
        m   = vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        mr  = vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        mb  = vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        mrb = vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);

        tbl[0] = '{z, O_0};
        tbl[1] = '{lu, O_HZ};
        tbl[2] = '{vin(3, 1, 0, 0, 3, 1, 0, 0, 0, 0), O_NF};
        tbl[3] = '{vin(0, 0, 5, 1, 0, 0, 0, 5, 1, 0), O_NF};
        tbl[4] = '{vin(3, 0, 0, 0, 3, 1, 1, 0, 0, 0), O_0};
        tbl[5] = '{vin(3, 1, 0, 0, 3, 0, 1, 0, 0, 0), O_0};
        tbl[6] = '{vin(3, 1, 0, 0, 3, 1, 1, 0, 0, 1), O_BR};
        tbl[7] = '{vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), O_BR};
        tbl[8] = '{vin(0, 0, 7, 1, 7, 1, 1, 0, 0, 0), O_HZ};
        tbl[9] = '{vin(0, 0, 7, 0, 7, 1, 1, 0, 0, 0), O_0};

        #2;
        chk("reset outs", 32'(w_o), 32'(O_0));
        chk("reset mem_err", 32'(mem_err), 32'd0);
        chk("reset stall_cnt", 32'(stall_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 0;

        for (int k = 0; k < 10; k++)
            cycle(tbl[k].i, $sformatf("vec%0d", k), 1, tbl[k].e);

        // Load-use bubble lasts one cycle and counts once.
        cycle(vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "lu clr", 1, O_0);
        cycle(lu, "lu bubble", 1, O_HZ);
        cycle(z, "lu after", 1, O_0);
        chk("lu stall_cnt", 32'(stall_cnt), 32'd1);

        // Memory completes on the third cycle.
        cycle(m, "mw1", 1, O_MS);
        cycle(m, "mw2", 1, O_MS);
        cycle(mr, "mw3", 1, O_0);
        cycle(z, "mw idle", 1, O_0);
        chk("mw mem_err", 32'(mem_err), 32'd0);

        // Branch held behind a memory stall flushes right after release.
        cycle(mb, "bms1", 1, O_MS);
        cycle(mb, "bms2", 1, O_MS);
        cycle(mrb, "bms release", 1, O_BR);
        cycle(z, "bms after", 1, O_0);

        // Saturating counter and clear priority.
        cycle(vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "cnt clr", 1, O_0);
        for (int k = 0; k < 4; k++) cycle(lu, "cnt hz", 1, O_HZ);
        chk("cnt sat", 32'(stall_cnt), 32'(CMAX));
        cycle(lu, "cnt hz5", 1, O_HZ);
        chk("cnt still sat", 32'(stall_cnt), 32'(CMAX));
        cycle(vin(3, 1, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 1), "cnt clr+hz", 1, O_HZ);
        chk("cnt cleared", 32'(stall_cnt), 32'd0);

        // Watchdog: four stall cycles, one released cycle, then a fresh stall from IDLE.
        for (int k = 1; k <= 3; k++) cycle(m, $sformatf("to%0d", k), 1, O_MS);
        chk("to mem_err early", 32'(mem_err), 32'd0);
        cycle(m, "to4", 1, O_MS);
        chk("to mem_err set", 32'(mem_err), 32'd1);
        cycle(m, "to5", 1, O_0);
        cycle(m, "to6", 1, O_MS);
        cycle(z, "to end", 1, O_0);
        chk("to mem_err sticky", 32'(mem_err), 32'd1);

        // Asynchronous reset in the middle of a wait.
        cycle(m, "rw1", 1, O_MS);
        cycle(m, "rw2", 1, O_MS);
        drive(m);
        #2;
        rst = 1;
        #1;
        chk("rst mid outs", 32'(w_o), 32'(O_0));
        chk("rst mid mem_err", 32'(mem_err), 32'd0);
        chk("rst mid stall_cnt", 32'(stall_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 0;
        m_k = 0; m_to = 0; m_err = 0; m_cnt = 0;
        for (int k = 1; k <= 3; k++) cycle(m, $sformatf("post rst%0d", k), 1, O_MS);
        cycle(mr, "post rst done", 1, O_0);

        for (int n = 0; n < 600; n++) begin
            r = vin($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                    $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
                    $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
            cycle(r, $sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the 5-stage ARM pipeline. It drives the Freeze and Flush inputs of the PC register and of the IF/ID, ID/EX and EX/MEM stage registers. Its decisions come from three sources:
- register read-after-write hazards detected in ID;
- taken branches resolved in EX;
- a multi-cycle data-memory handshake in MEM.

The memory path has a watchdog timeout, and the block keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- MAX_WAIT, 15, maximum consecutive memory-stall cycles before timeout (≥2)
- CNT_W, 16, stall counter width

Ports. Reset is rst, asynchronous, active-high; clock is clk.
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- id_src1  in  4  Rn index of the instruction in ID
- id_src1_valid  in  1  instruction reads Rn
- id_src2  in  4  Rm/Rd index read by the instruction in ID
- id_two_src  in  1  instruction reads src2
- exe_dest, mem_dest  in  4  destination register in EX / MEM
- exe_wb_en, mem_wb_en  in  1  writeback enable in EX / MEM
- exe_mem_r_en  in  1  instruction in EX is a load
- exe_branch_taken  in  1  taken branch resolved in EX
- mem_req  in  1  MEM-stage memory access pending
- mem_ready  in  1  memory completes the access this cycle
- stat_clr  in  1  synchronous clear of stall_cnt
- freeze_pc, freeze_if_id, freeze_id_ex, freeze_ex_mem  out  1  hold the corresponding register
- flush_if_id, flush_id_ex  out  1  zero the corresponding register
- hazard_stall  out  1  a RAW bubble is being inserted this cycle
- mem_err  out  1  sticky memory timeout flag
- stall_cnt  out  CNT_W  count of cycles with freeze_pc=1

## Operation
Hazard term:
- match(s,d,en) = en & (s==d).
- hz = (id_src1_valid & M(id_src1)) | (id_two_src & M(id_src2)).
- M(s) depends on the configuration (see Configuration).

Memory stall term:
- mem_stall = mem_req & ~mem_ready & (state≠TIMEOUT).

Output priority within a cycle (exactly one case applies; all unlisted outputs are 0):
1. mem_stall: all four freeze outputs = 1; both flushes = 0; hazard_stall = 0. The ID/EX Flush must not override its Freeze.
2. Else exe_branch_taken: flush_if_id = flush_id_ex = 1. Any hazard is ignored, because that instruction is being squashed.
3. Else hz: freeze_pc = freeze_if_id = 1; flush_id_ex = 1; hazard_stall = 1.

A taken branch that occurs during a memory stall stays in the frozen ID/EX register. Its flush is therefore issued on the first cycle after the stall releases.

FSM, with states IDLE, WAIT and TIMEOUT:
- IDLE:
  - mem_req & ~mem_ready → WAIT, wait_cnt ← 1.
  - Otherwise stay in IDLE.
- WAIT:
  - ~mem_req | mem_ready → IDLE, wait_cnt ← 0.
  - Else if wait_cnt == MAX_WAIT−1 → TIMEOUT, mem_err ← 1.
  - Else wait_cnt ← wait_cnt+1.
- TIMEOUT:
  - Freeze is released for one cycle so the faulting access retires.
  - Unconditionally → IDLE, wait_cnt ← 0.

Rules for mem_err and stall_cnt:
- mem_err stays set until rst.
- stall_cnt: if stat_clr, load 0 (priority over increment). Else if freeze_pc=1 and stall_cnt is not all-ones, increment. It saturates at 2^CNT_W−1.

## Timing
- All freeze, flush and hazard_stall outputs are combinational from the inputs and the FSM state, with zero-cycle latency. The stage registers sample them at the same edge.
- mem_err, stall_cnt, state and wait_cnt are registered.
- Reset values:
  - state = IDLE, wait_cnt = 0, mem_err = 0, stall_cnt = 0.
  - With all inputs at 0, every combinational output is 0.
- A load-use hazard inserts exactly one bubble cycle. In the next cycle the load has moved to MEM, so hz deasserts when forwarding is enabled.
- Memory stall length is min(latency, MAX_WAIT) cycles. The cycle after MAX_WAIT stall cycles is TIMEOUT, which has no freeze.
- mem_ready in the same cycle as mem_req: no stall, and the FSM stays in IDLE.
- rst mid-WAIT: the FSM returns to IDLE asynchronously and all freezes drop immediately.

## Configuration
- FORWARDING_EN defined:
  - M(s) = exe_mem_r_en & match(s, exe_dest, exe_wb_en).
  - Only load-use hazards stall; the forwarding unit covers all other hazards.
- FORWARDING_EN undefined:
  - M(s) = match(s, exe_dest, exe_wb_en) | match(s, mem_dest, mem_wb_en).
  - Any RAW dependence on EX or MEM stalls until the producer reaches WB.

## Test plan
- Load-use hazard, FORWARDING_EN: exe_mem_r_en=1, exe_wb_en=1, exe_dest=3, id_src1=3, id_src1_valid=1 → one cycle with freeze_pc=freeze_if_id=flush_id_ex=hazard_stall=1. Next cycle (EX no longer a load) → all 0. stall_cnt=1.
- No forwarding: mem_wb_en=1, mem_dest=5, id_two_src=1, id_src2=5 → hazard_stall=1. With FORWARDING_EN and the same stimulus → hazard_stall=0.
- Branch overrides hazard: exe_branch_taken=1 with hz true → flush_if_id=flush_id_ex=1, freeze_pc=0, hazard_stall=0.
- Memory wait, MAX_WAIT=4: mem_req=1, mem_ready rises on the 3rd cycle → all freezes =1 for 2 cycles then 0; FSM back in IDLE; mem_err=0.
- Timeout, MAX_WAIT=4: mem_ready held at 0 → freezes =1 for 4 cycles; 5th cycle freezes =0; mem_err=1 from the 5th cycle on; 6th cycle FSM in IDLE.
- Branch during memory stall, plus counter: exe_branch_taken=1 while mem_stall is active → flushes =0 until release, then =1 for one cycle. With CNT_W=2, four stall cycles → stall_cnt=3 and saturated; stat_clr → 0.
